// File: rtl/dds_waveform_generator.sv
// DDS waveform source: N-bit phase accumulator, six waveform shapes, config applied at phase wrap.
// Optional macro AMP_SCALE_EN adds cfg_amp and a third pipeline stage for amplitude scaling.
module dds_waveform_generator #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 8,
    parameter int LUT_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [2:0]         cfg_sel,
    input  logic [OUT_W-1:0]   cfg_duty,
`ifdef AMP_SCALE_EN
    input  logic [OUT_W-1:0]   cfg_amp,
`endif
    output logic [OUT_W-1:0]   wave,
    output logic               wave_valid,
    output logic               wrap
);
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int LUT_N  = 2 ** LUT_AW;
    localparam int LUT_BW = LUT_N * (OUT_W - 1);

    // Quarter-wave table built at elaboration; sin evaluated by Taylor series.
    function automatic logic [LUT_BW-1:0] build_lut();
        logic [LUT_BW-1:0] tbl;
        real x, term, s;
        tbl = '0;
        for (int k = 0; k < LUT_N; k++) begin
            x    = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
            term = x;
            s    = x;
            for (int n = 1; n < 10; n++) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
                s    = s + term;
            end
            tbl[k*(OUT_W-1) +: (OUT_W-1)] = (OUT_W-1)'($rtoi(s * real'(2 ** (OUT_W - 1) - 1) + 0.5));
        end
        return tbl;
    endfunction

    localparam logic [LUT_BW-1:0] LUT_BITS = build_lut();

    logic [PHASE_W-1:0] phase_q, phase_d, ftw_q, ftw_d, sh_ftw_q, sh_ftw_d;
    logic [OUT_W-1:0]   duty_q, duty_d, sh_duty_q, sh_duty_d;
    logic [2:0]         sel_q, sel_d, sh_sel_q, sh_sel_d;
    logic               pend_q, pend_d, carry_q, carry_d;
    logic [PHASE_W:0]   sum;
    logic               commit;

    logic [OUT_W-2:0]   m1_q, m1_d;
    logic [OUT_W-1:0]   t1_q, t1_d, r1_q, r1_d, duty1_q, duty1_d;
    logic [2:0]         sel1_q, sel1_d;
    logic               h1_q, h1_d, v1_q, v1_d, w1_q, w1_d;
    logic [LUT_AW-1:0]  lut_idx;
    int                 lut_off;

    logic [OUT_W-1:0]   x, m_ext, sine, s2_q, s2_d;
    logic               v2_q, v2_d, w2_q, w2_d;

`ifdef AMP_SCALE_EN
    logic [OUT_W-1:0]          amp_q, amp_d, sh_amp_q, sh_amp_d, amp1_q, amp1_d, amp2_q, amp2_d;
    logic [OUT_W-1:0]          wave3_q, wave3_d;
    logic                      v3_q, v3_d, w3_q, w3_d;
    logic signed [OUT_W:0]     diff;
    logic signed [2*OUT_W+1:0] prod, scaled;
`endif

    // Accumulator and config handshake; shadow commits on carry or when en drops.
    always_comb begin
        sum       = {1'b0, phase_q} + {1'b0, ftw_q};
        commit    = pend_q && (!en || sum[PHASE_W]);
        phase_d   = en ? sum[PHASE_W-1:0] : phase_q;
        carry_d   = en ? sum[PHASE_W] : carry_q;
        ftw_d     = ftw_q;
        duty_d    = duty_q;
        sel_d     = sel_q;
        sh_ftw_d  = sh_ftw_q;
        sh_duty_d = sh_duty_q;
        sh_sel_d  = sh_sel_q;
        pend_d    = pend_q;
`ifdef AMP_SCALE_EN
        amp_d     = amp_q;
        sh_amp_d  = sh_amp_q;
`endif
        if (commit) begin
            ftw_d  = sh_ftw_q;
            duty_d = sh_duty_q;
            sel_d  = sh_sel_q;
            pend_d = 1'b0;
`ifdef AMP_SCALE_EN
            amp_d  = sh_amp_q;
`endif
        end else if (cfg_valid && !pend_q) begin
            if (en) begin
                sh_ftw_d  = cfg_ftw;
                sh_duty_d = cfg_duty;
                sh_sel_d  = cfg_sel;
                pend_d    = 1'b1;
`ifdef AMP_SCALE_EN
                sh_amp_d  = cfg_amp;
`endif
            end else begin
                ftw_d  = cfg_ftw;
                duty_d = cfg_duty;
                sel_d  = cfg_sel;
`ifdef AMP_SCALE_EN
                amp_d  = cfg_amp;
`endif
            end
        end
    end

    always_comb begin
        lut_idx = phase_q[PHASE_W-2] ? ~phase_q[PHASE_W-3 -: LUT_AW] : phase_q[PHASE_W-3 -: LUT_AW];
        lut_off = int'(lut_idx) * (OUT_W - 1);
        m1_d    = m1_q;
        h1_d    = h1_q;
        t1_d    = t1_q;
        r1_d    = r1_q;
        sel1_d  = sel1_q;
        duty1_d = duty1_q;
`ifdef AMP_SCALE_EN
        amp1_d  = amp1_q;
`endif
        if (en) begin
            m1_d    = LUT_BITS[lut_off +: (OUT_W-1)];
            h1_d    = phase_q[PHASE_W-1];
            t1_d    = phase_q[PHASE_W-1 -: OUT_W];
            r1_d    = phase_q[PHASE_W-2 -: OUT_W];
            sel1_d  = sel_q;
            duty1_d = duty_q;
`ifdef AMP_SCALE_EN
            amp1_d  = amp_q;
`endif
        end
        v1_d = en;
        w1_d = en && carry_q;
    end

    always_comb begin
        m_ext = {1'b0, m1_q};
        sine  = h1_q ? MID - m_ext : MID + m_ext;
        case (sel1_q)
            3'd0:    x = t1_q;
            3'd1:    x = (t1_q < duty1_q) ? '1 : '0;
            3'd2:    x = h1_q ? ~r1_q : r1_q;
            3'd3:    x = sine;
            3'd4:    x = h1_q ? MID : sine;
            3'd5:    x = MID + m_ext;
            default: x = MID;
        endcase
        s2_d = v1_q ? x : s2_q;
        v2_d = v1_q;
        w2_d = v1_q && w1_q;
`ifdef AMP_SCALE_EN
        amp2_d  = v1_q ? amp1_q : amp2_q;
        diff    = $signed({1'b0, s2_q}) - $signed({1'b0, MID});
        prod    = diff * $signed({1'b0, amp2_q});
        scaled  = prod >>> OUT_W;
        wave3_d = v2_q ? MID + scaled[OUT_W-1:0] : wave3_q;
        v3_d    = v2_q;
        w3_d    = v2_q && w2_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            ftw_q     <= '0;
            duty_q    <= '0;
            sel_q     <= '0;
            sh_ftw_q  <= '0;
            sh_duty_q <= '0;
            sh_sel_q  <= '0;
            pend_q    <= 1'b0;
            carry_q   <= 1'b0;
            m1_q      <= '0;
            h1_q      <= 1'b0;
            t1_q      <= '0;
            r1_q      <= '0;
            sel1_q    <= '0;
            duty1_q   <= '0;
            v1_q      <= 1'b0;
            w1_q      <= 1'b0;
            s2_q      <= MID;
            v2_q      <= 1'b0;
            w2_q      <= 1'b0;
`ifdef AMP_SCALE_EN
            amp_q     <= '1;
            sh_amp_q  <= '1;
            amp1_q    <= '1;
            amp2_q    <= '1;
            wave3_q   <= MID;
            v3_q      <= 1'b0;
            w3_q      <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            ftw_q     <= ftw_d;
            duty_q    <= duty_d;
            sel_q     <= sel_d;
            sh_ftw_q  <= sh_ftw_d;
            sh_duty_q <= sh_duty_d;
            sh_sel_q  <= sh_sel_d;
            pend_q    <= pend_d;
            carry_q   <= carry_d;
            m1_q      <= m1_d;
            h1_q      <= h1_d;
            t1_q      <= t1_d;
            r1_q      <= r1_d;
            sel1_q    <= sel1_d;
            duty1_q   <= duty1_d;
            v1_q      <= v1_d;
            w1_q      <= w1_d;
            s2_q      <= s2_d;
            v2_q      <= v2_d;
            w2_q      <= w2_d;
`ifdef AMP_SCALE_EN
            amp_q     <= amp_d;
            sh_amp_q  <= sh_amp_d;
            amp1_q    <= amp1_d;
            amp2_q    <= amp2_d;
            wave3_q   <= wave3_d;
            v3_q      <= v3_d;
            w3_q      <= w3_d;
`endif
        end
    end

    assign cfg_ready = !pend_q;
`ifdef AMP_SCALE_EN
    assign wave       = wave3_q;
    assign wave_valid = v3_q;
    assign wrap       = w3_q;
`else
    assign wave       = s2_q;
    assign wave_valid = v2_q;
    assign wrap       = w2_q;
`endif

endmodule
